music_player: RTL

Playback engine for the pinball sound path. It generates the free-running 8-bit beat counter that drives the combinational melody ROMs. It takes back the 5-bit note index each ROM returns and turns that index into a square-wave audio output for the on-board buzzer/amplifier pin. Exactly one melody ROM is connected at a time; the top-level mux selects which ROM drives `note`.

---
 rtl/music_pkg.sv | 37 +++
 rtl/music_player_tone_gen.sv | 31 +++
 rtl/music_player.sv | 42 ++++
 3 files changed

// File: rtl/music_pkg.sv
// music_pkg: note index constants and half-period table shared by the melody path.
package music_pkg;
  localparam int NOTE_W = 5;
  localparam int HALF_W = 18;
  localparam logic [NOTE_W-1:0] S = 5'd0;
  localparam logic [NOTE_W-1:0] C4 = 5'd1, D4 = 5'd2, E4 = 5'd3, F4 = 5'd4, G4 = 5'd5, A4 = 5'd6, B4 = 5'd7;
  localparam logic [NOTE_W-1:0] C5 = 5'd8, D5 = 5'd9, E5 = 5'd10, F5 = 5'd11, G5 = 5'd12, A5 = 5'd13, B5 = 5'd14;
  localparam logic [NOTE_W-1:0] C6 = 5'd15, D6 = 5'd16, E6 = 5'd17, F6 = 5'd18, G6 = 5'd19, A6 = 5'd20, B6 = 5'd21;

  // Cycles per half period at 100 MHz; rests and out-of-range indices give 0.
  function automatic logic [HALF_W-1:0] note_half(input logic [NOTE_W-1:0] idx);
    case (idx)
      C4: note_half = 18'd190839;
      D4: note_half = 18'd170068;
      E4: note_half = 18'd151515;
      F4: note_half = 18'd143266;
      G4: note_half = 18'd127551;
      A4: note_half = 18'd113636;
      B4: note_half = 18'd101214;
      C5: note_half = 18'd95419;
      D5: note_half = 18'd85034;
      E5: note_half = 18'd75757;
      F5: note_half = 18'd71633;
      G5: note_half = 18'd63775;
      A5: note_half = 18'd56818;
      B5: note_half = 18'd50607;
      C6: note_half = 18'd47709;
      D6: note_half = 18'd42517;
      E6: note_half = 18'd37878;
      F6: note_half = 18'd35816;
      G6: note_half = 18'd31887;
      A6: note_half = 18'd28409;
      B6: note_half = 18'd25303;
      default: note_half = '0;
    endcase
  endfunction
endpackage

// File: rtl/music_player_tone_gen.sv
// tone_gen: registers the ROM note and produces a 50% square wave at its pitch.
module tone_gen
  import music_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NOTE_W-1:0] note,
  output logic              audio
);
  logic [NOTE_W-1:0] note_q;
  logic [HALF_W-1:0] tone_cnt, half;
  logic silent;
  always_comb begin
    half = note_half(note_q);
    silent = (note != note_q) || (half == '0);
  end
  always_ff @(posedge clk)
    if (rst) begin
      note_q <= '0;
      tone_cnt <= '0;
      audio <= 1'b0;
    end else if (!en) begin
      tone_cnt <= '0;
      audio <= 1'b0;
    end else begin
      note_q <= note;
      tone_cnt <= (silent || tone_cnt == half - HALF_W'(1)) ? '0 : tone_cnt + HALF_W'(1);
      audio <= silent ? 1'b0 : audio ^ (tone_cnt == half - HALF_W'(1));
    end
endmodule

// File: rtl/music_player.sv
// music_player: beat counter for the melody ROMs plus square-wave playback of the returned note.
module music_player
  import music_pkg::*;
#(
  parameter int BEAT_DIV = 12_500_000,
  parameter int BEAT_LEN = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NOTE_W-1:0] note,
  output logic [7:0]        beat_cnt,
  output logic              beat_tick,
  output logic              audio
);
  localparam int PW = $clog2(BEAT_DIV + 1);
  logic [PW-1:0] pre;
  logic wrap, last;
  always_comb begin
    wrap = pre == PW'(BEAT_DIV - 1);
    last = beat_cnt == 8'(BEAT_LEN - 1);
  end
  always_ff @(posedge clk)
    if (rst) begin
      pre <= '0;
      beat_cnt <= '0;
      beat_tick <= 1'b0;
    end else begin
      beat_tick <= en && wrap;
      if (en) begin
        pre <= wrap ? '0 : pre + PW'(1);
        if (wrap) beat_cnt <= last ? 8'd0 : beat_cnt + 8'd1;
      end
    end
  tone_gen u_tone (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .note (note),
    .audio(audio)
  );
endmodule
